// File: rtl/cr16_datapath_exec_if.sv
// Control-word interface between the CR16 sequencer (master) and the execute datapath (slave).
interface cr16_datapath_exec_if #(
    parameter int WIDTH = 16,
    parameter int NREGS = 16
);
    logic             ctrl_valid;
    logic             ctrl_ready;
    logic [7:0]       alu_op;
    logic [7:0]       muxes;
    logic [NREGS-1:0] regs_en;
    logic [WIDTH-1:0] imm;
    logic [WIDTH-1:0] ALU_output;
    logic [4:0]       flag_reg;
    logic             result_valid;

    modport master (
        output ctrl_valid, alu_op, muxes, regs_en, imm,
        input  ctrl_ready, ALU_output, flag_reg, result_valid
    );

    modport slave (
        input  ctrl_valid, alu_op, muxes, regs_en, imm,
        output ctrl_ready, ALU_output, flag_reg, result_valid
    );
endinterface

// File: rtl/cr16_datapath_exec.sv
// CR16 execute datapath: 16x16 register file, single-cycle ALU, registered result and {N,Z,F,L,C} flags.
// Optional 16-cycle shift-add multiplier on opcode C when CR16_MUL_EN is defined.
module cr16_datapath_exec #(
    parameter int WIDTH = 16,
    parameter int NREGS = 16
) (
    input  logic                clk,
    input  logic                reset,
    cr16_datapath_exec_if.slave bus
);
    localparam int FN = 4;
    localparam int FZ = 3;
    localparam int FF = 2;
    localparam int FL = 1;
    localparam int FC = 0;

    logic [WIDTH-1:0]        regs_rd [NREGS];
    logic [WIDTH-1:0]        alu_output_reg;
    logic [4:0]              flag_reg_reg;
    logic                    result_valid_reg;
    logic                    ctrl_ready_int;
    logic                    accept;
    logic [3:0]              opcode;
    logic [WIDTH-1:0]        op_a;
    logic [WIDTH-1:0]        op_b;
    logic [WIDTH:0]          sum_ext;
    logic [WIDTH:0]          diff_ext;
    logic signed [WIDTH-1:0] asr_res;
    logic [WIDTH-1:0]        result_next;
    logic [4:0]              flags_next;
    logic                    alu_write;
    logic                    mul_start;
    logic                    mul_done;
    logic [WIDTH-1:0]        mul_result;
    logic [NREGS-1:0]        mul_wr_en;
    logic [NREGS-1:0]        wr_mask;
    logic [WIDTH-1:0]        wr_data;
    logic [2:0]              unused_alu_bits;

    assign unused_alu_bits = bus.alu_op[6:4];
    assign opcode  = bus.alu_op[3:0];
    assign accept  = bus.ctrl_valid & ctrl_ready_int;
    assign op_a    = regs_rd[bus.muxes[3:0]];
    assign op_b    = bus.alu_op[7] ? bus.imm : regs_rd[bus.muxes[7:4]];
    assign asr_res = $signed(op_a) >>> op_b[3:0];

    // Defaults hold ALU_output/flags so NOPs and flag-neutral ops fall out naturally.
    always_comb begin
        sum_ext     = {1'b0, op_a} + {1'b0, op_b};
        diff_ext    = {1'b0, op_a} - {1'b0, op_b};
        result_next = alu_output_reg;
        flags_next  = flag_reg_reg;
        alu_write   = 1'b0;
        mul_start   = 1'b0;
        case (opcode)
            4'h0: begin
                result_next     = sum_ext[WIDTH-1:0];
                flags_next[FC]  = sum_ext[WIDTH];
                flags_next[FF]  = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                                  (sum_ext[WIDTH-1] != op_a[WIDTH-1]);
                alu_write       = 1'b1;
            end
            4'h1: begin
                result_next    = sum_ext[WIDTH-1:0];
                flags_next[FC] = sum_ext[WIDTH];
                alu_write      = 1'b1;
            end
            4'h2: begin
                result_next    = diff_ext[WIDTH-1:0];
                flags_next[FC] = diff_ext[WIDTH];
                flags_next[FF] = (op_a[WIDTH-1] != op_b[WIDTH-1]) &&
                                 (diff_ext[WIDTH-1] != op_a[WIDTH-1]);
                alu_write      = 1'b1;
            end
            4'h3: begin
                result_next    = diff_ext[WIDTH-1:0];
                flags_next[FZ] = (op_a == op_b);
                flags_next[FL] = diff_ext[WIDTH];
                flags_next[FN] = ($signed(op_a) < $signed(op_b));
            end
            4'h4: begin result_next = op_a & op_b; alu_write = 1'b1; end
            4'h5: begin result_next = op_a | op_b; alu_write = 1'b1; end
            4'h6: begin result_next = op_a ^ op_b; alu_write = 1'b1; end
            4'h7: begin result_next = ~op_a;       alu_write = 1'b1; end
            4'h8: begin
                result_next = op_b[4] ? (op_a >> op_b[3:0]) : (op_a << op_b[3:0]);
                alu_write   = 1'b1;
            end
            4'h9: begin
                result_next = op_b[4] ? asr_res : (op_a << op_b[3:0]);
                alu_write   = 1'b1;
            end
            4'hA: begin result_next = op_b; alu_write = 1'b1; end
            4'hB: begin result_next = {op_b[7:0], op_a[7:0]}; alu_write = 1'b1; end
`ifdef CR16_MUL_EN
            4'hC: mul_start = 1'b1;
`endif
            default: ;
        endcase
    end

`ifdef CR16_MUL_EN
    logic             mul_busy_reg;
    logic [3:0]       mul_cnt_reg;
    logic [WIDTH-1:0] mul_a_reg;
    logic [WIDTH-1:0] mul_b_reg;
    logic [WIDTH-1:0] mul_acc_reg;
    logic [NREGS-1:0] mul_en_reg;
    logic [WIDTH-1:0] mul_sum;

    // One multiplier bit per cycle; the 16th iteration's sum is written directly.
    assign mul_sum        = mul_acc_reg + (mul_b_reg[0] ? mul_a_reg : '0);
    assign mul_done       = mul_busy_reg && (mul_cnt_reg == 4'd15);
    assign mul_result     = mul_sum;
    assign mul_wr_en      = mul_en_reg;
    assign ctrl_ready_int = ~mul_busy_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            mul_busy_reg <= 1'b0;
            mul_cnt_reg  <= '0;
            mul_a_reg    <= '0;
            mul_b_reg    <= '0;
            mul_acc_reg  <= '0;
            mul_en_reg   <= '0;
        end else if (accept && mul_start) begin
            mul_busy_reg <= 1'b1;
            mul_cnt_reg  <= '0;
            mul_a_reg    <= op_a;
            mul_b_reg    <= op_b;
            mul_acc_reg  <= '0;
            mul_en_reg   <= bus.regs_en;
        end else if (mul_busy_reg) begin
            mul_acc_reg <= mul_sum;
            mul_a_reg   <= mul_a_reg << 1;
            mul_b_reg   <= mul_b_reg >> 1;
            mul_cnt_reg <= mul_cnt_reg + 4'd1;
            if (mul_done) mul_busy_reg <= 1'b0;
        end
    end
`else
    assign mul_done       = 1'b0;
    assign mul_result     = '0;
    assign mul_wr_en      = '0;
    assign ctrl_ready_int = 1'b1;
`endif

    always_comb begin
        wr_mask = '0;
        wr_data = result_next;
        if (mul_done) begin
            wr_mask = mul_wr_en;
            wr_data = mul_result;
        end else if (accept && alu_write) begin
            wr_mask = bus.regs_en;
        end
    end

    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
            logic [WIDTH-1:0] r_reg;
            always_ff @(posedge clk) begin
                if (!reset)           r_reg <= '0;
                else if (wr_mask[gi]) r_reg <= wr_data;
            end
            assign regs_rd[gi] = r_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            alu_output_reg   <= '0;
            flag_reg_reg     <= '0;
            result_valid_reg <= 1'b0;
        end else begin
            result_valid_reg <= (accept & ~mul_start) | mul_done;
            if (mul_done) begin
                alu_output_reg <= mul_result;
            end else if (accept) begin
                alu_output_reg <= result_next;
                flag_reg_reg   <= flags_next;
            end
        end
    end

    assign bus.ctrl_ready   = ctrl_ready_int;
    assign bus.ALU_output   = alu_output_reg;
    assign bus.flag_reg     = flag_reg_reg;
    assign bus.result_valid = result_valid_reg;
endmodule

// File: tb/tb_cr16_datapath_exec.sv
// Self-checking bench for cr16_datapath_exec: directed vectors plus randomized words against a behavioural model.
module tb_cr16_datapath_exec;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cr16_datapath_exec_if bus ();
    cr16_datapath_exec dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int errors = 0;

    int unsigned m_regs [16];
    int unsigned m_out;
    logic [4:0]  m_flags;

    logic [15:0] obs_out;
    logic [4:0]  obs_flags;
    logic        obs_rv;

    function automatic int to_s(input int unsigned x);
        return (x >= 32'd32768) ? int'(x) - 65536 : int'(x);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 0;
        m_out   = 0;
        m_flags = '0;
    endtask

    // Reference semantics of one accepted word, in plain integer arithmetic.
    task automatic model_step(input logic [7:0] op, input logic [7:0] mx,
                              input logic [15:0] en, input logic [15:0] im);
        int unsigned a, b, r, sh;
        int sa, sb, s;
        bit wr, upd;
        a   = m_regs[mx[3:0]];
        b   = op[7] ? 32'(im) : m_regs[mx[7:4]];
        sa  = to_s(a);
        sb  = to_s(b);
        sh  = b % 16;
        r   = 0;
        wr  = 1'b1;
        upd = 1'b1;
        case (op[3:0])
            4'h0: begin
                r = (a + b) & 32'hFFFF;
                m_flags[0] = (a + b) > 32'd65535;
                s = sa + sb;
                m_flags[2] = (s > 32767) || (s < -32768);
            end
            4'h1: begin
                r = (a + b) & 32'hFFFF;
                m_flags[0] = (a + b) > 32'd65535;
            end
            4'h2: begin
                r = (a - b) & 32'hFFFF;
                m_flags[0] = a < b;
                s = sa - sb;
                m_flags[2] = (s > 32767) || (s < -32768);
            end
            4'h3: begin
                r  = (a - b) & 32'hFFFF;
                wr = 1'b0;
                m_flags[3] = (a == b);
                m_flags[1] = (a < b);
                m_flags[4] = (sa < sb);
            end
            4'h4: r = a & b;
            4'h5: r = a | b;
            4'h6: r = a ^ b;
            4'h7: r = (~a) & 32'hFFFF;
            4'h8: r = ((b & 32'h10) != 0) ? (a >> sh) : ((a << sh) & 32'hFFFF);
            4'h9: begin
                if ((b & 32'h10) != 0) begin
                    s = sa >>> sh;
                    r = unsigned'(s) & 32'hFFFF;
                end else begin
                    r = (a << sh) & 32'hFFFF;
                end
            end
            4'hA: r = b;
            4'hB: r = ((b & 32'hFF) << 8) | (a & 32'hFF);
`ifdef CR16_MUL_EN
            4'hC: r = (a * b) & 32'hFFFF;
`endif
            default: begin wr = 1'b0; upd = 1'b0; end
        endcase
        if (upd) m_out = r;
        if (wr) for (int i = 0; i < 16; i++) if (en[i]) m_regs[i] = r;
    endtask

    task automatic send_word(input logic [7:0] op, input logic [7:0] mx,
                             input logic [15:0] en, input logic [15:0] im);
        int waited;
        waited         = 0;
        bus.alu_op     = op;
        bus.muxes      = mx;
        bus.regs_en    = en;
        bus.imm        = im;
        bus.ctrl_valid = 1'b1;
        while (bus.ctrl_ready !== 1'b1 && waited < 64) begin
            @(posedge clk); #1;
            waited++;
        end
        if (waited >= 64) begin
            checks++; errors++;
            $display("FAIL ready_timeout: ctrl_ready=%b required 1", bus.ctrl_ready);
        end
        @(posedge clk); #1;
        bus.ctrl_valid = 1'b0;
        model_step(op, mx, en, im);
        obs_out   = bus.ALU_output;
        obs_flags = bus.flag_reg;
        obs_rv    = bus.result_valid;
        $display("word op=%h mx=%h en=%h imm=%h -> out=%h flags=%b rv=%b",
                 op, mx, en, im, obs_out, obs_flags, obs_rv);
    endtask

    task automatic read_reg(input logic [3:0] n);
        send_word(8'h0A, {n, 4'h0}, 16'h0000, 16'h0000);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < 6; i++)
            send_word({4'h8, 4'(i % 4)}, 8'($urandom), 16'($urandom), 16'($urandom));
        send_word(8'h8A, 8'h00, 16'hFFFF, 16'hA5A5);
        // Reset asserted alongside a valid word: reset must win.
        bus.alu_op = 8'h8A; bus.muxes = 8'h00; bus.regs_en = 16'hFFFF; bus.imm = 16'h1234;
        bus.ctrl_valid = 1'b1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        bus.ctrl_valid = 1'b0;
        model_reset();
        checks++; if (bus.ALU_output !== 16'h0000) begin errors++; $display("FAIL reset_out: got %h required 0000", bus.ALU_output); end
        checks++; if (bus.flag_reg !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b required 00000", bus.flag_reg); end
        checks++; if (bus.ctrl_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", bus.ctrl_ready); end
        checks++; if (bus.result_valid !== 1'b0) begin errors++; $display("FAIL reset_rv: got %b required 0", bus.result_valid); end
        for (int n = 0; n < 16; n++) begin
            read_reg(4'(n));
            checks++; if (obs_out !== 16'h0000) begin errors++; $display("FAIL reset_reg R%0d: got %h required 0000", n, obs_out); end
        end
    endtask

    task automatic test_spec_vectors();
        send_word(8'h8A, 8'h00, 16'h0002, 16'h7FFF);
        checks++; if (obs_rv !== 1'b1 || obs_out !== 16'h7FFF) begin errors++; $display("FAIL mov_imm: got out=%h rv=%b required 7fff rv=1", obs_out, obs_rv); end
        send_word(8'h80, 8'h01, 16'h0004, 16'h0001);
        checks++; if (obs_rv !== 1'b1 || obs_out !== 16'h8000) begin errors++; $display("FAIL add_ovf_out: got out=%h rv=%b required 8000 rv=1", obs_out, obs_rv); end
        checks++; if (obs_flags[2] !== 1'b1 || obs_flags[0] !== 1'b0) begin errors++; $display("FAIL add_ovf_flags: got %b required F=1 C=0", obs_flags); end
        read_reg(4'd2);
        checks++; if (obs_out !== 16'h8000) begin errors++; $display("FAIL add_dest_R2: got %h required 8000", obs_out); end
        send_word(8'h8A, 8'h00, 16'h0008, 16'h0000);
        send_word(8'h82, 8'h03, 16'h0010, 16'h0001);
        checks++; if (obs_out !== 16'hFFFF || obs_flags[0] !== 1'b1) begin errors++; $display("FAIL sub_borrow: got out=%h flags=%b required ffff C=1", obs_out, obs_flags); end
        send_word(8'h03, 8'h33, 16'hFFFF, 16'h0000);
        checks++; if (obs_flags[3] !== 1'b1 || obs_flags[1] !== 1'b0 || obs_flags[4] !== 1'b0 || obs_out !== 16'h0000)
            begin errors++; $display("FAIL cmp_equal: got out=%h flags=%b required 0000 Z=1 L=0 N=0", obs_out, obs_flags); end
        read_reg(4'd3);
        checks++; if (obs_out !== 16'h0000) begin errors++; $display("FAIL cmp_no_write: got R3=%h required 0000", obs_out); end
        send_word(8'h83, 8'h04, 16'h0000, 16'h0001);
        checks++; if (obs_flags[1] !== 1'b0 || obs_flags[4] !== 1'b1 || obs_flags[3] !== 1'b0 || obs_flags !== m_flags)
            begin errors++; $display("FAIL cmp_signed: got %b required L=0 N=1 Z=0 (%b)", obs_flags, m_flags); end
        send_word(8'h8A, 8'h00, 16'h0020, 16'h0001);
        send_word(8'h88, 8'h05, 16'h0040, 16'h000F);
        checks++; if (obs_out !== 16'h8000) begin errors++; $display("FAIL lsh_left: got %h required 8000", obs_out); end
        send_word(8'h89, 8'h06, 16'h0080, 16'h0013);
        checks++; if (obs_out !== 16'hF000) begin errors++; $display("FAIL ashu_right: got %h required f000", obs_out); end
    endtask

    task automatic test_fibonacci();
        send_word(8'h8A, 8'h00, 16'h0001, 16'h0000);
        send_word(8'h8A, 8'h00, 16'h0002, 16'h0001);
        for (int k = 0; k < 10; k++) begin
            send_word(8'h00, 8'h10, 16'h0004, 16'h0000);
            send_word(8'h0A, 8'h10, 16'h0001, 16'h0000);
            send_word(8'h0A, 8'h20, 16'h0002, 16'h0000);
        end
        read_reg(4'd1);
        checks++; if (obs_out !== 16'h0059) begin errors++; $display("FAIL fibonacci_R1: got %h required 0059", obs_out); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] base;
        base = 16'($urandom);
        send_word(8'h8A, 8'h00, 16'h0200, base);
        for (int k = 1; k <= 5; k++) begin
            send_word(8'h81, 8'h09, 16'h0200, 16'h0001);
            checks++; if (obs_out !== 16'(base + 16'(k))) begin errors++; $display("FAIL back_to_back step %0d: got %h required %h", k, obs_out, 16'(base + 16'(k))); end
        end
    endtask

    task automatic test_nop();
        for (int op = 12; op < 16; op++) begin
`ifdef CR16_MUL_EN
            if (op == 12) continue;
`endif
            send_word({4'h8, 4'(op)}, 8'($urandom), 16'hFFFF, 16'($urandom));
            checks++; if (obs_rv !== 1'b1 || obs_out !== 16'(m_out) || obs_flags !== m_flags)
                begin errors++; $display("FAIL nop_%0h: got out=%h flags=%b rv=%b required %h %b 1", op, obs_out, obs_flags, obs_rv, 16'(m_out), m_flags); end
        end
        read_reg(4'd7);
        checks++; if (obs_out !== 16'(m_regs[7])) begin errors++; $display("FAIL nop_no_write: got %h required %h", obs_out, 16'(m_regs[7])); end
    endtask

    task automatic test_random();
        logic [7:0] op;
        for (int t = 0; t < 300; t++) begin
            op = 8'($urandom);
`ifdef CR16_MUL_EN
            if (op[3:0] == 4'hC) op[3:0] = 4'hD;
`endif
            send_word(op, 8'($urandom), 16'($urandom), 16'($urandom));
            checks++; if (obs_rv !== 1'b1 || obs_out !== 16'(m_out) || obs_flags !== m_flags)
                begin errors++; $display("FAIL random_%0d op=%h: got out=%h flags=%b rv=%b required %h %b 1", t, op, obs_out, obs_flags, obs_rv, 16'(m_out), m_flags); end
            if ($urandom_range(0, 7) == 0) begin
                @(posedge clk); #1;
                checks++; if (bus.result_valid !== 1'b0 || bus.ALU_output !== 16'(m_out) || bus.flag_reg !== m_flags)
                    begin errors++; $display("FAIL idle_hold: got out=%h flags=%b rv=%b required %h %b 0", bus.ALU_output, bus.flag_reg, bus.result_valid, 16'(m_out), m_flags); end
            end
        end
        for (int n = 0; n < 16; n++) begin
            read_reg(4'(n));
            checks++; if (obs_out !== 16'(m_regs[n])) begin errors++; $display("FAIL random_reg R%0d: got %h required %h", n, obs_out, 16'(m_regs[n])); end
        end
    endtask

`ifdef CR16_MUL_EN
    task automatic test_mul();
        int low, rv_seen;
        send_word(8'h8A, 8'h00, 16'h0020, 16'h0123);
        bus.alu_op = 8'h8C; bus.muxes = 8'h05; bus.regs_en = 16'h0040; bus.imm = 16'h0045;
        bus.ctrl_valid = 1'b1;
        @(posedge clk); #1;
        model_step(8'h8C, 8'h05, 16'h0040, 16'h0045);
        bus.alu_op = 8'h8A; bus.muxes = 8'h00; bus.regs_en = 16'h0080; bus.imm = 16'h1111;
        low = 0; rv_seen = 0;
        while (bus.ctrl_ready !== 1'b1 && low < 40) begin
            low++;
            if (bus.result_valid === 1'b1) rv_seen++;
            @(posedge clk); #1;
        end
        checks++; if (low != 16) begin errors++; $display("FAIL mul_stall: ready low %0d cycles required 16", low); end
        checks++; if (rv_seen != 0) begin errors++; $display("FAIL mul_early_rv: got %0d pulses required 0", rv_seen); end
        checks++; if (bus.result_valid !== 1'b1 || bus.ALU_output !== 16'h4E6F || bus.ALU_output !== 16'(m_out))
            begin errors++; $display("FAIL mul_result: got out=%h rv=%b required 4e6f rv=1", bus.ALU_output, bus.result_valid); end
        @(posedge clk); #1;
        bus.ctrl_valid = 1'b0;
        model_step(8'h8A, 8'h00, 16'h0080, 16'h1111);
        checks++; if (bus.ALU_output !== 16'h1111 || bus.result_valid !== 1'b1)
            begin errors++; $display("FAIL mul_held_word: got out=%h rv=%b required 1111 rv=1", bus.ALU_output, bus.result_valid); end
        read_reg(4'd6);
        checks++; if (obs_out !== 16'h4E6F) begin errors++; $display("FAIL mul_dest_R6: got %h required 4e6f", obs_out); end
        bus.alu_op = 8'h8C; bus.muxes = 8'h05; bus.regs_en = 16'h0100; bus.imm = 16'h0045;
        bus.ctrl_valid = 1'b1;
        @(posedge clk); #1;
        bus.ctrl_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        model_reset();
        checks++; if (bus.ctrl_ready !== 1'b1 || bus.ALU_output !== 16'h0000)
            begin errors++; $display("FAIL mul_abort: got ready=%b out=%h required 1 0000", bus.ctrl_ready, bus.ALU_output); end
        rv_seen = 0;
        repeat (20) begin @(posedge clk); #1; if (bus.result_valid === 1'b1) rv_seen++; end
        checks++; if (rv_seen != 0) begin errors++; $display("FAIL mul_abort_rv: got %0d pulses required 0", rv_seen); end
        read_reg(4'd8);
        checks++; if (obs_out !== 16'h0000) begin errors++; $display("FAIL mul_abort_R8: got %h required 0000", obs_out); end
    endtask
`endif

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b0;
        bus.ctrl_valid = 1'b0;
        bus.alu_op     = '0;
        bus.muxes      = '0;
        bus.regs_en    = '0;
        bus.imm        = '0;
        model_reset();
        @(posedge clk); #1;
        test_reset();
        test_spec_vectors();
        test_fibonacci();
        test_back_to_back();
        test_nop();
        test_random();
`ifdef CR16_MUL_EN
        test_mul();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
